serial_link_gen: RTL and testbench

//  Parametrised serial transfer unit: WIDTH-bit shift register (SB) + control reg (SC),

---
 rtl/serial_link_pkg.sv | 10 +
 rtl/serial_clk_gen.sv | 43 ++++
 rtl/serial_link_gen.sv | 116 +++++++++++
 tb/tb_serial_link_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared register map and FSM state encoding for the serial link
package serial_link_pkg;
    localparam int SC_START   = 7;
    localparam int SC_INT_CLK = 0;
    localparam int SC_FAST    = 1;
    localparam int SC_LSB     = 2;
    localparam logic ADDR_SB  = 1'b0;
    localparam logic ADDR_SC  = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;
endpackage

// File: rtl/serial_clk_gen.sv
// serial_clk_gen: SCK edge events from the internal prescaler or the synchronised external clock
module serial_clk_gen #(
    parameter int HALF_PERIOD      = 256,
    parameter int HALF_PERIOD_FAST = 8,
    parameter int SYNC_STAGES      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    input  logic int_clk,
    input  logic fast,
    input  logic sck_in,
    output logic fall_ev,
    output logic rise_ev
);
    localparam int HP_MAX = HALF_PERIOD > HALF_PERIOD_FAST ? HALF_PERIOD : HALF_PERIOD_FAST;
    localparam int PW = $clog2(HP_MAX);
    logic [PW-1:0] presc, hp_last;
    logic [SYNC_STAGES-1:0] sync;
    logic sck_prev, tick, s_rise, s_fall;
    assign hp_last = fast ? PW'(HALF_PERIOD_FAST - 1) : PW'(HALF_PERIOD - 1);
    assign tick    = run && int_clk && presc == hp_last;
    assign s_rise  = sync[SYNC_STAGES-1] && !sck_prev;
    assign s_fall  = !sync[SYNC_STAGES-1] && sck_prev;
    // internal mode alternates fall/rise on each tick; the FSM phase picks which one applies
    assign fall_ev = int_clk ? tick : s_fall;
    assign rise_ev = int_clk ? tick : s_rise;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            sync     <= '0;
            sck_prev <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], sck_in};
            sck_prev <= sync[SYNC_STAGES-1];
            if (clr)
                presc <= '0;
            else if (run && int_clk)
                presc <= tick ? '0 : presc + 1'b1;
        end
    end
endmodule

// File: rtl/serial_link_gen.sv
// serial_link_gen: SB/SC register pair driving a master/slave serial shift transfer
module serial_link_gen
    import serial_link_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int HALF_PERIOD      = 256,
    parameter int HALF_PERIOD_FAST = 8,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             addr,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_oe,
    input  logic             sck_in,
    input  logic             sin_in,
    output logic             sck_out,
    output logic             sck_oe,
    output logic             ser_out,
    output logic             busy,
    output logic             irq
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_n;
    logic [WIDTH-1:0] sr, sr_n, sc_val;
    logic [CW-1:0] bit_cnt, bit_cnt_n, cnt_inc;
    logic [2:0] mode, mode_n;
    logic sck_n, ser_n, irq_n, start, fall_ev, rise_ev, wr_sb, wr_sc, tx_bit;
    assign wr_sb   = sel && cpu_wr && addr == ADDR_SB;
    assign wr_sc   = sel && cpu_wr && addr == ADDR_SC;
    assign busy    = state != ST_IDLE;
    assign sck_oe  = mode[SC_INT_CLK];
    assign d_oe    = sel && cpu_rd;
    assign cnt_inc = bit_cnt + 1'b1;
    assign tx_bit  = mode[SC_LSB] ? sr[0] : sr[WIDTH-1];
    assign d_out   = !d_oe ? '0 : addr == ADDR_SC ? sc_val : sr;
    always_comb begin
        sc_val = '0;
        sc_val[SC_START] = busy;
        sc_val[2:0] = mode;
    end
    serial_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD),
        .HALF_PERIOD_FAST(HALF_PERIOD_FAST),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_clk (
        .clk(clk),
        .reset(reset),
        .run(busy),
        .clr(start),
        .int_clk(mode[SC_INT_CLK]),
        .fast(mode[SC_FAST]),
        .sck_in(sck_in),
        .fall_ev(fall_ev),
        .rise_ev(rise_ev)
    );
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        mode_n    = mode;
        sck_n     = sck_out;
        ser_n     = ser_out;
        irq_n     = 1'b0;
        start     = 1'b0;
        if (state == ST_IDLE) begin
            if (wr_sb)
                sr_n = d_in;
            if (wr_sc) begin
                mode_n = d_in[2:0];
                if (d_in[SC_START]) begin
                    start     = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = ST_HIGH;
                end
            end
        end else if (wr_sc && !d_in[SC_START]) begin
            // abort beats any edge on the same clock
            state_n = ST_IDLE;
            sck_n   = 1'b1;
        end else if (state == ST_HIGH && fall_ev) begin
            sck_n   = !mode[SC_INT_CLK];
            ser_n   = tx_bit;
            state_n = ST_LOW;
        end else if (state == ST_LOW && rise_ev) begin
            sck_n     = 1'b1;
            sr_n      = mode[SC_LSB] ? {sin_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin_in};
            bit_cnt_n = cnt_inc;
            irq_n     = cnt_inc == CW'(WIDTH);
            state_n   = cnt_inc == CW'(WIDTH) ? ST_IDLE : ST_HIGH;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            mode    <= '0;
            sck_out <= 1'b1;
            ser_out <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            bit_cnt <= bit_cnt_n;
            mode    <= mode_n;
            sck_out <= sck_n;
            ser_out <= ser_n;
            irq     <= irq_n;
        end
    end
endmodule

// File: tb/tb_serial_link_gen.sv
// tb_serial_link_gen: randomized and directed checks of serial_link_gen against a transfer-level model
module tb_serial_link_gen;
    localparam int HP = 256, HPF = 8, S = 2;
    logic clk = 0, reset = 0, sel8 = 0, sel16 = 0, addr = 0, cpu_wr = 0, cpu_rd = 0;
    logic sck_in = 1, sin_drv = 0, loop8 = 0;
    logic [15:0] d_in = 0;
    logic [7:0] dout8;
    logic [15:0] dout16;
    logic doe8, sck8, sckoe8, ser8, busy8, irq8, sin8;
    logic doe16, sck16, sckoe16, ser16, busy16, irq16, sin16;
    assign sin8  = loop8 ? ser8 : sin_drv;
    assign sin16 = ser16;
    always #5 clk = ~clk;

    serial_link_gen #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .sel(sel8), .addr(addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .d_in(d_in[7:0]), .d_out(dout8), .d_oe(doe8), .sck_in(sck_in), .sin_in(sin8),
        .sck_out(sck8), .sck_oe(sckoe8), .ser_out(ser8), .busy(busy8), .irq(irq8));
    serial_link_gen #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .sel(sel16), .addr(addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .d_in(d_in), .d_out(dout16), .d_oe(doe16), .sck_in(sck_in), .sin_in(sin16),
        .sck_out(sck16), .sck_oe(sckoe16), .ser_out(ser16), .busy(busy16), .irq(irq16));

    int n_chk = 0, n_fail = 0, irq_cnt = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // result of k shifts of o with sample s[0] taken first
    function automatic logic [7:0] shifted(input logic [7:0] o, input logic [7:0] s, input int k, input bit lsb);
        logic [7:0] r;
        if (!lsb) begin
            r = o << k;
            for (int i = 0; i < k; i++) r[k-1-i] = s[i];
        end else begin
            r = o >> k;
            for (int i = 0; i < k; i++) r[8-k+i] = s[i];
        end
        return r;
    endfunction

    int cyc = 0, m_e0 = 0, m_half = 0;
    bit m_busy = 0, m_sck = 1, m_ser = 0, m_irq = 0;
    logic [2:0] m_mode = 0;
    logic [7:0] m_sr = 0, m_orig = 0, m_samp = 0;
    bit hist [0:S+1];
    always @(posedge clk or posedge reset) begin
        bit ev, ext_rise, ext_fall;
        int hp, k;
        if (reset) begin
            m_busy = 0; m_sck = 1; m_ser = 0; m_irq = 0; m_mode = 0; m_sr = 0; m_half = 0;
            for (int j = 0; j <= S + 1; j++) hist[j] = 0;
        end else begin
            cyc++;
            for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sck_in;
            ext_rise = hist[S] && !hist[S+1];
            ext_fall = !hist[S] && hist[S+1];
            m_irq = 0;
            if (!m_busy) begin
                if (sel8 && cpu_wr && !addr) m_sr = d_in[7:0];
                if (sel8 && cpu_wr && addr) begin
                    m_mode = d_in[2:0];
                    if (d_in[7]) begin
                        m_busy = 1; m_e0 = cyc; m_half = 0; m_orig = m_sr; m_samp = 0;
                    end
                end
            end else if (sel8 && cpu_wr && addr && !d_in[7]) begin
                m_busy = 0; m_sck = 1;
            end else begin
                hp = m_mode[1] ? HPF : HP;
                ev = m_mode[0] ? ((cyc - m_e0) % hp == 0) : (m_half % 2 == 0 ? ext_fall : ext_rise);
                if (ev) begin
                    k = m_half / 2;
                    if (m_half % 2 == 0) begin
                        m_ser = m_mode[2] ? m_orig[k] : m_orig[7-k];
                        if (m_mode[0]) m_sck = 0;
                    end else begin
                        m_samp[k] = sin8;
                        m_sr = shifted(m_orig, m_samp, k + 1, m_mode[2]);
                        m_sck = 1;
                        if (k == 7) begin m_busy = 0; m_irq = 1; end
                    end
                    m_half++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic eo;
        eo = sel8 && cpu_rd;
        chk("sck_out", sck8, m_sck);
        chk("ser_out", ser8, m_ser);
        chk("busy", busy8, m_busy);
        chk("irq", irq8, m_irq);
        chk("sck_oe", sckoe8, m_mode[0]);
        chk("d_oe", doe8, eo);
        chk("d_out", dout8, eo ? (addr ? {m_busy, 4'b0, m_mode} : m_sr) : 8'h0);
        if (irq8) irq_cnt++;
    end

    task automatic tick(); @(posedge clk); #2; endtask
    task automatic wr8(input logic a, input logic [7:0] v);
        sel8 = 1; cpu_rd = 0; cpu_wr = 1; addr = a; d_in = {8'h0, v};
        tick();
        sel8 = 0; cpu_wr = 0;
    endtask
    task automatic rd8(input logic a, output logic [7:0] v);
        sel8 = 1; cpu_rd = 1; cpu_wr = 0; addr = a; #1 v = dout8; sel8 = 0; cpu_rd = 0;
    endtask
    task automatic wr16(input logic a, input logic [15:0] v);
        sel16 = 1; cpu_rd = 0; cpu_wr = 1; addr = a; d_in = v;
        tick();
        sel16 = 0; cpu_wr = 0;
    endtask
    task automatic wait_irq8(output int n, output logic [7:0] bits);
        logic p;
        n = 0; bits = 0;
        while (!irq8 && n < 20000) begin
            p = sck8; tick(); n++;
            if (p && !sck8) bits = {bits[6:0], ser8};
        end
    endtask
    task automatic wait_irq16(output int n, output logic [15:0] bits);
        logic p;
        n = 0; bits = 0;
        while (!irq16 && n < 20000) begin
            p = sck16; tick(); n++;
            if (p && !sck16) bits = {bits[14:0], ser16};
        end
    endtask
    task automatic ext_byte(input logic [7:0] pat, input int lo, input int hi);
        for (int i = 7; i >= 0; i--) begin
            sin_drv = pat[i]; sck_in = 0;
            repeat (lo) tick();
            sck_in = 1;
            repeat (hi) tick();
        end
    endtask

    initial begin
        logic [7:0] v, b;
        logic [15:0] b16;
        int n, c0, abort_at;
        bit ext;
        #1 reset = 1;
        repeat (3) tick();
        reset = 0;
        rd8(0, v); chk("rst_sb", v, 8'h00);
        rd8(1, v); chk("rst_sc", v, 8'h00);
        chk("rst_sck", sck8, 1'b1);
        // internal normal MSB-first
        sin_drv = 1; c0 = irq_cnt;
        wr8(0, 8'hA5); wr8(1, 8'h81);
        wait_irq8(n, b);
        chk("t1_irq_time", n, 4096);
        chk("t1_bits", b, 8'hA5);
        tick();
        rd8(0, v); chk("t1_sb", v, 8'hFF);
        rd8(1, v); chk("t1_sc", v, 8'h01);
        chk("t1_ser_hold", ser8, 1'b1);
        chk("t1_irq_cnt", irq_cnt - c0, 1);
        // fast LSB-first loopback
        loop8 = 1;
        wr8(0, 8'h01); wr8(1, 8'h87);
        wait_irq8(n, b);
        chk("t2_irq_time", n, 128);
        chk("t2_bits", b, 8'h80);
        tick();
        rd8(0, v); chk("t2_sb", v, 8'h01);
        loop8 = 0;
        // external clock slave
        c0 = irq_cnt;
        wr8(1, 8'h80);
        chk("t3_sck_oe", sckoe8, 1'b0);
        ext_byte(8'h3C, 10, 10);
        repeat (5) tick();
        chk("t3_irq_cnt", irq_cnt - c0, 1);
        chk("t3_busy", busy8, 1'b0);
        rd8(0, v); chk("t3_sb", v, 8'h3C);
        ext_byte(8'hFF, 5, 5);
        rd8(0, v); chk("t3_idle_sb", v, 8'h3C);
        // abort after three bits, SB write while busy ignored
        sin_drv = 1; c0 = irq_cnt;
        wr8(0, 8'hA5); wr8(1, 8'h81);
        repeat (1536) tick();
        wr8(0, 8'h55);
        wr8(1, 8'h01);
        chk("t4_busy", busy8, 1'b0);
        chk("t4_sck", sck8, 1'b1);
        repeat (300) tick();
        chk("t4_no_irq", irq_cnt - c0, 0);
        rd8(0, v); chk("t4_sb", v, 8'h2F);
        rd8(1, v); chk("t4_sc", v, 8'h01);
        // abort on the same edge as the final rise
        sin_drv = 0; c0 = irq_cnt;
        wr8(0, 8'hC3); wr8(1, 8'h83);
        repeat (127) tick();
        wr8(1, 8'h03);
        chk("tab_busy", busy8, 1'b0);
        repeat (20) tick();
        chk("tab_no_irq", irq_cnt - c0, 0);
        rd8(0, v); chk("tab_sb", v, 8'h80);
        // reset mid-transfer
        sin_drv = 1;
        wr8(0, 8'h5A); wr8(1, 8'h81);
        repeat (2570) tick();
        c0 = irq_cnt;
        reset = 1;
        #1;
        chk("t5_sck", sck8, 1'b1);
        chk("t5_ser", ser8, 1'b0);
        chk("t5_busy", busy8, 1'b0);
        chk("t5_irq", irq8, 1'b0);
        tick();
        reset = 0;
        rd8(0, v); chk("t5_sb", v, 8'h00);
        rd8(1, v); chk("t5_sc", v, 8'h00);
        repeat (10) tick();
        chk("t5_no_irq", irq_cnt - c0, 0);
        // 16-bit loopback
        wr16(0, 16'hBEEF); wr16(1, 16'h0081);
        wait_irq16(n, b16);
        chk("t6_irq_time", n, 8192);
        chk("t6_bits", b16, 16'hBEEF);
        tick();
        sel16 = 1; cpu_rd = 1; addr = 0; #1;
        chk("t6_sb", dout16, 16'hBEEF);
        sel16 = 0; cpu_rd = 0;
        chk("t6_busy", busy16, 1'b0);
        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            ext = $urandom_range(0, 5) == 0;
            wr8(0, 8'($urandom));
            wr8(1, {1'b1, 4'b0, 1'($urandom), 1'b1, !ext});
            if (ext) begin
                for (int i = 0; i < 8; i++) begin
                    sin_drv = 1'($urandom); sck_in = 0;
                    repeat ($urandom_range(2, 8)) tick();
                    sck_in = 1;
                    repeat ($urandom_range(2, 8)) tick();
                end
                repeat (6) tick();
            end else begin
                abort_at = $urandom_range(0, 3) == 0 ? $urandom_range(1, 120) : -1;
                for (int c = 0; c < 200 && busy8; c++) begin
                    sin_drv = 1'($urandom);
                    sel8 = 1'($urandom); cpu_rd = 1'($urandom); addr = 1'($urandom);
                    if (c == abort_at)
                        wr8(1, {1'b0, 7'($urandom)});
                    else if ($urandom_range(0, 15) == 0)
                        wr8(1'($urandom), {1'($urandom), 4'b0, 1'($urandom), 2'b11});
                    else
                        tick();
                end
            end
            sel8 = 0; cpu_rd = 0;
            if (busy8) wr8(1, 8'h00);
            tick();
        end
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
